// File: rtl/nn_pkg.sv
// Shared constants for the neuron datapath.
// Words are fixed point with 24 fractional bits, so 1.0 is 32'h0100_0000.
// Lane k of a packed layer vector occupies bits [k*WORD_W +: WORD_W].
package nn_pkg;
  localparam int WORD_W    = 32;
  localparam int FRAC_BITS = 24;
  localparam int LAYER_N   = 32;
  localparam int LANE_CW   = 6;   // holds a lane count 0..LAYER_N
  localparam logic [WORD_W-1:0] FIX_ONE = 32'h0100_0000;

  // Bit offset of lane k inside a packed layer vector.
  function automatic int lane_lsb(input int k);
    return k * WORD_W;
  endfunction
endpackage

// File: rtl/act_bank.sv
// One storage bank of the ping-pong activation buffer.
// Holds N lanes of activ and sigma_prime, the number of lanes written
// in the closed frame, and a full flag.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_wr_en         write lane i_wr_lane with i_wr_activ / i_wr_sp
//   i_close         mark the bank full, latch i_close_count
//   i_clear         release the bank: zero every lane, drop full
//   o_full, o_count full flag and lane count of the stored frame
//   o_activ, o_sp   packed lane contents
module act_bank
  import nn_pkg::*;
#(
  parameter int N  = LAYER_N,
  parameter int W  = WORD_W,
  parameter int CW = LANE_CW,
  parameter int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_wr_en,
  input  logic [IW-1:0]   i_wr_lane,
  input  logic [W-1:0]    i_wr_activ,
  input  logic [W-1:0]    i_wr_sp,
  input  logic            i_close,
  input  logic [CW-1:0]   i_close_count,
  input  logic            i_clear,
  output logic            o_full,
  output logic [CW-1:0]   o_count,
  output logic [N*W-1:0]  o_activ,
  output logic [N*W-1:0]  o_sp
);

  logic            r_full;
  logic [CW-1:0]   r_count;
  logic [N*W-1:0]  r_activ;
  logic [N*W-1:0]  r_sp;

  // Lane storage, full flag and count. A clear only happens on a full
  // bank and a write/close only on a non-full one, so they never overlap;
  // clearing every lane is what makes unwritten lanes of a short frame 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full  <= 1'b0;
      r_count <= '0;
      r_activ <= '0;
      r_sp    <= '0;
    end else if (i_clear) begin
      r_full  <= 1'b0;
      r_count <= '0;
      r_activ <= '0;
      r_sp    <= '0;
    end else begin
      if (i_wr_en) begin
        r_activ[i_wr_lane*W +: W] <= i_wr_activ;
        r_sp[i_wr_lane*W +: W]    <= i_wr_sp;
      end
      if (i_close) begin
        r_full  <= 1'b1;
        r_count <= i_close_count;
      end
    end
  end

  assign o_full  = r_full;
  assign o_count = r_count;
  assign o_activ = r_activ;
  assign o_sp    = r_sp;

endmodule

// File: rtl/layer_act_buffer.sv
// Ping-pong buffer that packs serial activ / sigma_prime words of one
// layer into N-lane vectors for the next layer.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             word handshake (in_ready depends only on state)
//   in_activ, in_sigma_prime      lane data
//   in_last                       close the frame after this word
//   out_valid/out_ready           frame handshake
//   out_activ, out_sigma_prime    packed frame, lane k at [k*W +: W]
//   out_count                     lanes written in the presented frame
module layer_act_buffer
  import nn_pkg::*;
#(
  parameter int N  = LAYER_N,
  parameter int W  = WORD_W,
  parameter int CW = LANE_CW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_activ,
  input  logic [W-1:0]    in_sigma_prime,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*W-1:0]  out_activ,
  output logic [N*W-1:0]  out_sigma_prime,
  output logic [CW-1:0]   out_count
);

  localparam int IW = $clog2(N);

  logic            r_wr_ptr;
  logic            r_rd_ptr;
  logic [IW-1:0]   r_idx;

  logic            w_full  [2];
  logic [CW-1:0]   w_count [2];
  logic [N*W-1:0]  w_activ [2];
  logic [N*W-1:0]  w_sp    [2];

  logic            w_accept;
  logic            w_close;
  logic            w_release;
  logic [CW-1:0]   w_close_count;

  assign in_ready      = !w_full[r_wr_ptr];
  assign out_valid     = w_full[r_rd_ptr];
  assign w_accept      = in_valid && in_ready;
  assign w_close       = w_accept && ((r_idx == IW'(N-1)) || in_last);
  assign w_release     = out_valid && out_ready;
  assign w_close_count = CW'(r_idx) + CW'(1);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    act_bank #(.N(N), .W(W), .CW(CW), .IW(IW)) u_bank (
      .clk           (clk),
      .rst           (rst),
      .i_wr_en       (w_accept  && (r_wr_ptr == 1'(b))),
      .i_wr_lane     (r_idx),
      .i_wr_activ    (in_activ),
      .i_wr_sp       (in_sigma_prime),
      .i_close       (w_close   && (r_wr_ptr == 1'(b))),
      .i_close_count (w_close_count),
      .i_clear       (w_release && (r_rd_ptr == 1'(b))),
      .o_full        (w_full[b]),
      .o_count       (w_count[b]),
      .o_activ       (w_activ[b]),
      .o_sp          (w_sp[b])
    );
  end

  // Fill lane index and bank pointers; a close resets the lane index and
  // hands the fill side to the other bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_idx    <= '0;
    end else begin
      if (w_close) begin
        r_idx    <= '0;
        r_wr_ptr <= ~r_wr_ptr;
      end else if (w_accept) begin
        r_idx    <= r_idx + IW'(1);
      end else begin
        r_idx    <= r_idx;
      end
      if (w_release) begin
        r_rd_ptr <= ~r_rd_ptr;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
    end
  end

  // Present the read bank; the fill bank may alias rd_ptr while partially
  // written, so data is forced to zero whenever no frame is presented.
  always_comb begin
    out_activ       = '0;
    out_sigma_prime = '0;
    out_count       = '0;
    if (w_full[r_rd_ptr]) begin
      out_activ       = w_activ[r_rd_ptr];
      out_sigma_prime = w_sp[r_rd_ptr];
      out_count       = w_count[r_rd_ptr];
    end else begin
      out_activ       = '0;
      out_sigma_prime = '0;
      out_count       = '0;
    end
  end

endmodule

// File: doc/layer_act_buffer.md
Name: layer_act_buffer

Overview:
- Downstream stage of a 32-input neuron.
- Collects the serial 32-bit activ / sigma_prime results of one layer, one word per handshake, and packs them lane-by-lane into 1024-bit vectors.
- These vectors form the prev_activ operand of the next layer; the sigma_prime vector is retained for backprop.
- Double-buffered (ping-pong), so the producer fills one frame while the consumer holds the other.

Parameters:
- N, 32, lanes per frame (neurons per layer).
- W, 32, word width; fixed point with 24 fractional bits, 1.0 = 32'h0100_0000.
- CW, 6, lane-count width, clog2(N)+1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  buffer can accept a word this cycle.
- in_activ  input  W  neuron activation.
- in_sigma_prime  input  W  neuron sigmoid derivative.
- in_last  input  1  word closes the frame early (fewer than N lanes).
- out_valid  output  1  a complete frame is presented.
- out_ready  input  1  consumer takes the frame.
- out_activ  output  N*W  packed activations; lane k at [k*W +: W].
- out_sigma_prime  output  N*W  packed derivatives, same lane mapping.
- out_count  output  CW  number of written lanes in the presented frame, 1..N.

Behaviour:
- Storage: two banks (0, 1), each N lanes of activ + sigma_prime, a lane count and a full flag. wr_ptr selects the fill bank, rd_ptr the presented bank.
- Reset (rst=1 at edge):
  - All bank contents zeroed; full flags cleared; fill lane index = 0; wr_ptr = rd_ptr = 0.
  - Outputs after reset: in_ready=1, out_valid=0, out_activ=0, out_sigma_prime=0, out_count=0.
  - Reset mid-frame or mid-handshake discards everything with no partial output.
- Input accept: a word is accepted when in_valid && in_ready.
  - in_ready = !full[wr_ptr]; combinational from registered state only, with no in_valid→in_ready path.
- On accept:
  - Write lane idx of bank wr_ptr.
  - If idx==N-1 or in_last: set full[wr_ptr], count[wr_ptr]=idx+1, idx←0, wr_ptr toggles.
  - Otherwise idx←idx+1.
  - in_last on lane N-1 is identical to a normal close.
- Output:
  - out_valid = full[rd_ptr]; out_* driven from bank rd_ptr.
  - All data outputs are zero whenever out_valid=0.
  - On out_valid && out_ready: full[rd_ptr]←0, all lanes of that bank cleared to zero, rd_ptr toggles.
  - The zero-clear guarantees that unwritten lanes of a short frame read as 0.
- Latency: the word closing a frame at edge t gives out_valid=1 after edge t (visible in cycle t+1), provided the other bank is not ahead in the queue.
- Frame ordering is strict FIFO: at most 2 frames held.
  - Both full → in_ready=0 until the consumer releases one.
- Simultaneous events:
  - Release of bank A and closing of bank B in the same cycle are both honoured.
  - Release of bank X and the first write into X cannot coincide, because in_ready was 0 for X in that cycle.
- Data outputs are stable while out_valid=1 && out_ready=0.
- No arithmetic on data; lane index wraps only via the close rule and never exceeds N-1.

Decomposition:
- Shared package nn_pkg holds WORD_W=32, FRAC_BITS=24, FIX_ONE=32'h0100_0000, LAYER_N=32, and the lane-slice convention.
- One natural sub-module: act_bank (one bank: lane write port, clear, full/count registers), instantiated twice. The top level holds the pointers, lane index and handshake logic.

Test Plan:
- Reset then feed 32 words, activ=k·0x0100_0000 and sigma_prime=k for k=0..31, out_ready=1 → out_valid rises the cycle after word 31; out_activ[k*32 +: 32]=k·0x0100_0000; out_count=32; single-cycle valid.
- Short frame: 5 words with in_last on the 5th → out_count=5; lanes 5..31 read 0 in both vectors.
- Backpressure: out_ready=0, stream 64+ words → two frames held; in_ready=0 from the cycle after word 63; release one frame → in_ready=1 next cycle; frame order preserved (first frame's lane 0 seen first).
- Simultaneous: release frame A in the same cycle word 31 of frame B is accepted → next cycle out_valid=1 with frame B data; no lost or duplicated frame.
- Mid-frame reset: assert rst after 17 words, hold 1 cycle → out_valid=0, in_ready=1, all outputs 0; a subsequent full frame packs from lane 0.
- Stability: hold out_ready=0 for 10 cycles with a frame presented → out_activ/out_sigma_prime/out_count unchanged every cycle.
